// File: rtl/urv_test_mem.sv
// urv_test_mem: shared I/D RAM, LFSR wait-state injection, console FIFO and test-done mailbox for urv_cpu benches
module urv_test_mem #(
   parameter int          MEM_WORDS     = 16384,
   parameter int          IM_STALL_RATE = 0,
   parameter int          DM_STALL_RATE = 0,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter logic [31:0] CONSOLE_ADDR  = 32'h00100000,
   parameter logic [31:0] DONE_ADDR     = 32'h00100004,
   parameter int          CON_DEPTH     = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] im_addr_i,
   output logic [31:0] im_data_o,
   output logic        im_valid_o,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_store_i,
   input  logic        dm_load_i,
   output logic        dm_ready_o,
   output logic [31:0] dm_data_l_o,
   output logic        dm_store_done_o,
   output logic        dm_load_done_o,
   input  logic        ld_we_i,
   input  logic [31:0] ld_addr_i,
   input  logic [31:0] ld_data_i,
   output logic [7:0]  con_data_o,
   output logic        con_valid_o,
   input  logic        con_ready_i,
   output logic        con_overflow_o,
   input  logic        test_clr_i,
   output logic        test_done_o,
   output logic [31:0] test_status_o
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(CON_DEPTH);
   localparam logic [7:0] IM_RATE = 8'(IM_STALL_RATE);
   localparam logic [7:0] DM_RATE = 8'(DM_STALL_RATE);

   logic [31:0]   mem [MEM_WORDS];
   logic [7:0]    con_mem [CON_DEPTH];
   logic [15:0]   lfsr;
   logic [CW-1:0] wr_ptr, rd_ptr;
   logic [CW:0]   con_count;
   logic [AW-1:0] im_idx, dm_idx, ld_idx;
   logic          acc_st, acc_ld, hit_con, hit_done, con_full, push, pop, push_ok;

   always_comb begin
      im_idx      = im_addr_i[AW+1:2];
      dm_idx      = dm_addr_i[AW+1:2];
      ld_idx      = ld_addr_i[AW-1:0];
      hit_con     = dm_addr_i == CONSOLE_ADDR;
      hit_done    = dm_addr_i == DONE_ADDR;
      acc_st      = dm_store_i & dm_ready_o;
      acc_ld      = dm_load_i & !dm_store_i & dm_ready_o;
      con_valid_o = con_count != '0;
      con_full    = con_count == (CW+1)'(CON_DEPTH);
      con_data_o  = con_valid_o ? con_mem[rd_ptr] : 8'h00;
      pop         = con_valid_o & con_ready_i;
      push        = acc_st & hit_con;
      push_ok     = push & (!con_full | pop);
   end

   // Loader write is issued last so it overrides a same-word data store.
   always_ff @(posedge clk_i) begin
      if (acc_st && !hit_con && !hit_done)
         for (int b = 0; b < 4; b++)
            if (dm_data_select_i[b]) mem[dm_idx][8*b +: 8] <= dm_data_s_i[8*b +: 8];
      if (ld_we_i) mem[ld_idx] <= ld_data_i;
      if (push_ok) con_mem[wr_ptr] <= dm_data_s_i[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lfsr            <= LFSR_SEED;
         im_data_o       <= '0;
         im_valid_o      <= 1'b0;
         dm_ready_o      <= 1'b0;
         dm_data_l_o     <= '0;
         dm_store_done_o <= 1'b0;
         dm_load_done_o  <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         con_count       <= '0;
         con_overflow_o  <= 1'b0;
         test_done_o     <= 1'b0;
         test_status_o   <= '0;
      end else begin
         lfsr            <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         im_data_o       <= mem[im_idx];
         im_valid_o      <= !(lfsr[7:0] < IM_RATE);
         dm_ready_o      <= !(lfsr[15:8] < DM_RATE);
         dm_store_done_o <= acc_st;
         dm_load_done_o  <= acc_ld;
         if (acc_ld) dm_data_l_o <= hit_con ? 32'(con_count) : hit_done ? test_status_o : mem[dm_idx];
         if (acc_st && hit_done) begin
            test_done_o   <= 1'b1;
            test_status_o <= dm_data_s_i;
         end else if (test_clr_i) begin
            test_done_o   <= 1'b0;
            test_status_o <= '0;
         end
         if (test_clr_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            con_count      <= '0;
            con_overflow_o <= 1'b0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + CW'(1);
            if (pop) rd_ptr <= rd_ptr + CW'(1);
            con_count <= con_count + (CW+1)'(push_ok) - (CW+1)'(pop);
            if (push && !push_ok) con_overflow_o <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_urv_test_mem.sv
// tb_urv_test_mem: directed checks of urv_test_mem; second instance exercises data-port stalls
module tb_urv_test_mem;
   localparam logic [31:0] CON = 32'h00100000;
   localparam logic [31:0] DONE = 32'h00100004;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [31:0] im_addr, im_data, dm_addr, dm_wdata, dm_rdata, ld_addr, ld_data, status;
   logic [3:0]  dm_sel;
   logic        im_valid, dm_store, dm_load, dm_ready, st_done, ld_done, ld_we;
   logic [7:0]  con_data;
   logic        con_valid, con_ready, con_ovf, clr, done;

   logic [31:0] b_im_addr, b_im_data, b_addr, b_wdata, b_rdata, b_ld_addr, b_ld_data, b_status;
   logic [3:0]  b_sel;
   logic        b_im_valid, b_store, b_load, b_ready, b_st_done, b_ld_done, b_ld_we;
   logic [7:0]  b_con_data;
   logic        b_con_valid, b_con_ready, b_con_ovf, b_clr, b_done;

   int checks = 0, errors = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   urv_test_mem #(.MEM_WORDS(256)) u0 (
      .clk_i(clk), .rst_n_i(rst_n), .im_addr_i(im_addr), .im_data_o(im_data), .im_valid_o(im_valid),
      .dm_addr_i(dm_addr), .dm_data_s_i(dm_wdata), .dm_data_select_i(dm_sel), .dm_store_i(dm_store),
      .dm_load_i(dm_load), .dm_ready_o(dm_ready), .dm_data_l_o(dm_rdata), .dm_store_done_o(st_done),
      .dm_load_done_o(ld_done), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
      .con_data_o(con_data), .con_valid_o(con_valid), .con_ready_i(con_ready), .con_overflow_o(con_ovf),
      .test_clr_i(clr), .test_done_o(done), .test_status_o(status));

   urv_test_mem #(.MEM_WORDS(256), .DM_STALL_RATE(128)) u1 (
      .clk_i(clk), .rst_n_i(rst_n), .im_addr_i(b_im_addr), .im_data_o(b_im_data), .im_valid_o(b_im_valid),
      .dm_addr_i(b_addr), .dm_data_s_i(b_wdata), .dm_data_select_i(b_sel), .dm_store_i(b_store),
      .dm_load_i(b_load), .dm_ready_o(b_ready), .dm_data_l_o(b_rdata), .dm_store_done_o(b_st_done),
      .dm_load_done_o(b_ld_done), .ld_we_i(b_ld_we), .ld_addr_i(b_ld_addr), .ld_data_i(b_ld_data),
      .con_data_o(b_con_data), .con_valid_o(b_con_valid), .con_ready_i(b_con_ready), .con_overflow_o(b_con_ovf),
      .test_clr_i(b_clr), .test_done_o(b_done), .test_status_o(b_status));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      dm_store = 1'b1; dm_addr = a; dm_wdata = d; dm_sel = s;
      @(negedge clk);
      check("st_done", {31'b0, st_done}, 32'd1);
      dm_store = 1'b0;
   endtask

   task automatic ld(input logic [31:0] a, output logic [31:0] d);
      dm_load = 1'b1; dm_addr = a;
      @(negedge clk);
      check("ld_done", {31'b0, ld_done}, 32'd1);
      d = dm_rdata;
      dm_load = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] w, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = w; ld_data = d;
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   initial begin
      logic [31:0] model [8];
      logic        exp_done;
      int          rdy_cnt, w, k;
      {im_addr, dm_addr, dm_wdata, ld_addr, ld_data, dm_sel, dm_store, dm_load, ld_we, con_ready, clr} = '0;
      {b_im_addr, b_addr, b_wdata, b_ld_addr, b_ld_data, b_sel, b_store, b_load, b_ld_we, b_con_ready, b_clr} = '0;
      repeat (2) @(negedge clk);
      check("rst_im_valid", {31'b0, im_valid}, 32'd0);
      check("rst_ready", {31'b0, dm_ready}, 32'd0);
      check("rst_im_data", im_data, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_con_valid", {31'b0, con_valid}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", {31'b0, dm_ready}, 32'd1);
      // instruction fetch and read-first
      load_word(0, 32'h13);
      @(negedge clk);
      check("im_data", im_data, 32'h13);
      check("im_valid", {31'b0, im_valid}, 32'd1);
      load_word(2, 32'hA);
      im_addr = 32'h8;
      load_word(2, 32'hB);
      check("im_read_first", im_data, 32'hA);
      @(negedge clk);
      check("im_new", im_data, 32'hB);
      // byte-masked store
      load_word(16, 32'h11223344);
      st(32'h40, 32'hAABBCCDD, 4'b0010);
      ld(32'h40, rd);
      check("byte_mask", rd, 32'h1122CC44);
      @(negedge clk);
      check("ld_done_pulse", {31'b0, ld_done}, 32'd0);
      // console FIFO
      st(CON, 32'h48, 4'h0);
      check("con_valid", {31'b0, con_valid}, 32'd1);
      check("con_data", {24'b0, con_data}, 32'h48);
      for (int i = 1; i <= 15; i++) st(CON, i, 4'hF);
      check("no_ovf_16", {31'b0, con_ovf}, 32'd0);
      st(CON, 32'd16, 4'hF);
      check("ovf_17", {31'b0, con_ovf}, 32'd1);
      ld(CON, rd);
      check("con_count_full", rd, 32'd16);
      con_ready = 1'b1;
      @(negedge clk);
      con_ready = 1'b0;
      check("con_pop_head", {24'b0, con_data}, 32'h01);
      ld(CON, rd);
      check("con_count_pop", rd, 32'd15);
      // done mailbox
      load_word(1, 32'h55);
      st(DONE, 32'h1, 4'hF);
      check("done_set", {31'b0, done}, 32'd1);
      check("status", status, 32'h1);
      ld(32'h4, rd);
      check("done_ram_untouched", rd, 32'h55);
      ld(DONE, rd);
      check("status_load", rd, 32'h1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_done", {31'b0, done}, 32'd0);
      check("clr_status", status, 32'd0);
      check("clr_ovf", {31'b0, con_ovf}, 32'd0);
      check("clr_fifo", {31'b0, con_valid}, 32'd0);
      clr = 1'b1;
      st(DONE, 32'h7, 4'hF);
      clr = 1'b0;
      check("clr_vs_store_done", {31'b0, done}, 32'd1);
      check("clr_vs_store_status", status, 32'h7);
      // aliasing and loader priority
      st((256 + 3) * 4, 32'hCAFE, 4'hF);
      ld(32'hC, rd);
      check("alias", rd, 32'hCAFE);
      ld_we = 1'b1; ld_addr = 5; ld_data = 32'h1234;
      st(32'h14, 32'hFFFFFFFF, 4'hF);
      ld_we = 1'b0;
      ld(32'h14, rd);
      check("loader_wins", rd, 32'h1234);
      // stalled data port
      for (int i = 0; i < 8; i++) begin
         b_ld_we = 1'b1; b_ld_addr = i; b_ld_data = 0; model[i] = 0;
         @(negedge clk);
      end
      b_ld_we = 1'b0;
      exp_done = 1'b0;
      rdy_cnt = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         check("stall_st_done", {31'b0, b_st_done}, {31'b0, exp_done});
         if (b_ready) rdy_cnt++;
         w = int'($urandom_range(0, 7));
         b_store = 1'($urandom_range(0, 1));
         b_addr = 32'(w) << 2;
         b_wdata = $urandom;
         b_sel = 4'($urandom_range(0, 15));
         exp_done = b_store & b_ready;
         if (exp_done)
            for (int b = 0; b < 4; b++)
               if (b_sel[b]) model[w][8*b +: 8] = b_wdata[8*b +: 8];
      end
      @(negedge clk);
      check("stall_st_done_last", {31'b0, b_st_done}, {31'b0, exp_done});
      b_store = 1'b0;
      check("ready_fraction", {31'b0, rdy_cnt >= 800 && rdy_cnt <= 1200}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         k = 0;
         while (!b_ready && k < 100) begin
            @(negedge clk);
            k++;
         end
         check("stall_wait", {31'b0, k < 100}, 32'd1);
         b_load = 1'b1; b_addr = 32'(i) << 2;
         @(negedge clk);
         check("stall_ld_done", {31'b0, b_ld_done}, 32'd1);
         check("stall_ram", b_rdata, model[i]);
         b_load = 1'b0;
      end
      // asynchronous reset with a partly filled FIFO
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < 3; i++) st(CON, 32'h30 + i, 4'hF);
      check("pre_rst_valid", {31'b0, con_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_con_valid", {31'b0, con_valid}, 32'd0);
      check("arst_con_data", {24'b0, con_data}, 32'd0);
      check("arst_im", {im_data[30:0], im_valid}, 32'd0);
      check("arst_ready", {31'b0, dm_ready}, 32'd0);
      check("arst_done", {status[30:0], done}, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
